// File: rtl/aer_event_tx_if.sv
// AER event transmitter bus: sorter event stream in,
// 4-phase REQ/ACK AER link and status out.
interface aer_event_tx_if #(
  parameter int AW = 10
);
  logic [AW-1:0] NEXT_INDEX;
  logic          FOUND_NEXT_INDEX;
  logic          INFERENCE_DONE;
  logic          AERIN_CTRL_BUSY;
  logic [AW-1:0] AEROUT_ADDR;
  logic          AEROUT_REQ;
  logic          AEROUT_ACK;
  logic [AW-1:0] EVENTS_SENT;
  logic          OVERFLOW;

  modport master (
    input  NEXT_INDEX,
    input  FOUND_NEXT_INDEX,
    input  INFERENCE_DONE,
    input  AEROUT_ACK,
    output AERIN_CTRL_BUSY,
    output AEROUT_ADDR,
    output AEROUT_REQ,
    output EVENTS_SENT,
    output OVERFLOW
  );

  modport slave (
    output NEXT_INDEX,
    output FOUND_NEXT_INDEX,
    output INFERENCE_DONE,
    output AEROUT_ACK,
    input  AERIN_CTRL_BUSY,
    input  AEROUT_ADDR,
    input  AEROUT_REQ,
    input  EVENTS_SENT,
    input  OVERFLOW
  );
endinterface

// File: rtl/aer_event_tx.sv
// Sorter-to-AER bridge: edge-detects sorter strobes, buffers
// addresses in a small FIFO and sends them over 4-phase REQ/ACK.
module aer_event_tx #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int FIFO_DEPTH      = 4
) (
  input  logic          CLK,
  input  logic          RST,
  aer_event_tx_if.master bus
);
  localparam int AW = IMAGE_SIZE_BITS + 2;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO
  } state_e;

  state_e        state_q, state_d;
  logic          fnd_prev_q, fnd_prev_d;
  logic          found_q, found_d;
  logic          ack_meta_q, ack_meta_d;
  logic          ack_s_q, ack_s_d;
  logic [AW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] mem_d [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic flush;
  logic empty;
  logic full;
  logic push;
  logic pop;

  assign flush = bus.INFERENCE_DONE;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  always_comb begin
    state_d    = state_q;
    fnd_prev_d = bus.FOUND_NEXT_INDEX;
    found_d    = bus.FOUND_NEXT_INDEX & ~fnd_prev_q & ~flush;
    ack_meta_d = bus.AEROUT_ACK;
    ack_s_d    = ack_meta_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    pop        = 1'b0;
    push       = found_q & ~flush;

    unique case (state_q)
      IDLE: begin
        if (!empty && !flush) begin
          pop     = 1'b1;
          addr_d  = mem_q[rd_ptr_q[PW-1:0]];
          state_d = SETUP;
        end
      end
      SETUP: state_d = REQ_HI;
      REQ_HI: begin
        if (ack_s_q) state_d = REQ_LO;
      end
      REQ_LO: begin
        if (!ack_s_q) begin
          state_d = IDLE;
          cnt_d   = cnt_q + AW'(1);
        end
      end
    endcase

    // A full FIFO still accepts when the head leaves this cycle
    if (push && full && !pop) ovf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push && (!full || pop)) begin
        mem_d[wr_ptr_q[PW-1:0]] = bus.NEXT_INDEX;
        wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      fnd_prev_q <= 1'b0;
      found_q    <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fnd_prev_q <= fnd_prev_d;
      found_q    <= found_d;
      ack_meta_q <= ack_meta_d;
      ack_s_q    <= ack_s_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.AEROUT_REQ      = (state_q == REQ_HI);
  assign bus.AEROUT_ADDR     = addr_q;
  assign bus.EVENTS_SENT     = cnt_q;
  assign bus.OVERFLOW        = ovf_q;
  assign bus.AERIN_CTRL_BUSY = found_q | ~empty | (state_q != IDLE);
endmodule
